// File: rtl/ghost_sprite_renderer.sv
// Ghost sprite fetch stage: beam position -> sprite RAM address -> pixel colour, 3-cycle latency.
// Optional fright recolouring/flash is enabled by defining FRIGHT_FLASH_EN.
module ghost_sprite_renderer #(
  parameter int unsigned SPR_W           = 26,
  parameter int unsigned SPR_H           = 26,
  parameter int unsigned ADDR_W          = 10,
  parameter logic [23:0] TRANSPARENT_KEY = 24'h000000,
  parameter int unsigned FLASH_BIT       = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        ghost_x,
  input  logic [9:0]        ghost_y,
  input  logic              facing_left,
  input  logic              frightened,
  input  logic              fright_ending,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [23:0]       ram_data,
  output logic [23:0]       pixel_rgb,
  output logic              pixel_hit
);

  logic [9:0]        pos_x_q, pos_y_q;
  logic              mirror_q, fright_q, ending_q;
  logic              hit_s1_q, hit_s2_q;

  logic [10:0]       dx, dy, col;
  logic              inbox;
  logic [ADDR_W-1:0] addr_d;
  logic              opaque;
  logic [23:0]       colour;

  // 11-bit differences keep a sprite near X=1023 from wrapping onto the left edge.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, pos_x_q};
    dy     = {1'b0, DrawY} - {1'b0, pos_y_q};
    inbox  = ({1'b0, DrawX} >= {1'b0, pos_x_q}) && (dx < 11'(SPR_W)) &&
             ({1'b0, DrawY} >= {1'b0, pos_y_q}) && (dy < 11'(SPR_H));
    col    = mirror_q ? (11'(SPR_W - 1) - dx) : dx;
    addr_d = ADDR_W'(dy * 11'(SPR_W) + col);
    opaque = hit_s2_q && (ram_data != TRANSPARENT_KEY);
  end

`ifdef FRIGHT_FLASH_EN
  logic [5:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n || !fright_q) begin
      cnt_q <= '0;
    end else if (frame_start) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  always_comb begin
    colour = ram_data;
    if (fright_q) begin
      colour = (ending_q && cnt_q[FLASH_BIT]) ? 24'hFFFFFF : 24'h2121FF;
    end
  end
`else
  logic unused_fright;
  assign unused_fright = ^{fright_q, ending_q, (FLASH_BIT != 0)};

  always_comb begin
    colour = ram_data;
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      mirror_q  <= 1'b0;
      fright_q  <= 1'b0;
      ending_q  <= 1'b0;
      ram_addr  <= '0;
      hit_s1_q  <= 1'b0;
      hit_s2_q  <= 1'b0;
      pixel_hit <= 1'b0;
      pixel_rgb <= '0;
    end else begin
      if (frame_start) begin
        pos_x_q  <= ghost_x;
        pos_y_q  <= ghost_y;
        mirror_q <= facing_left;
        fright_q <= frightened;
        ending_q <= fright_ending;
      end
      ram_addr  <= inbox ? addr_d : '0;
      hit_s1_q  <= inbox;
      hit_s2_q  <= hit_s1_q;
      pixel_hit <= opaque;
      pixel_rgb <= opaque ? colour : 24'h0;
    end
  end

endmodule
